ball_col_detect: RTL

//  Collision detector feeding the ball position controller: consumes ball and player top-left

---
 rtl/ball_col_detect.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ball_col_detect.sv
// Ball collision detector: periodically snapshots ball/player positions, runs one
// time-shared squared-distance engine over both players plus a box test against the
// net, and stretches every hit so a slow downstream FSM cannot miss it.
module ball_col_detect #(
    parameter int SAMPLE_DIV  = 1024,
    parameter int HOLD_CYCLES = 650_000,
    parameter int BALL_R      = 32,
    parameter int PL_CX       = 38,
    parameter int PL_CY       = 45,
    parameter int COL_R       = 70,
    parameter int NET_XL      = 507,
    parameter int NET_XR      = 517,
    parameter int NET_TOP     = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] ball_posx,
    input  logic [11:0] ball_posy,
    input  logic [11:0] pl1_posx,
    input  logic [11:0] pl1_posy,
    input  logic [11:0] pl2_posx,
    input  logic [11:0] pl2_posy,
    output logic        pl1_col,
    output logic        pl2_col,
    output logic        net_col,
    output logic        hit_valid
);
    localparam int          CW     = $clog2(SAMPLE_DIV);
    localparam int          HW     = $clog2(HOLD_CYCLES + 1);
    localparam logic [24:0] COL_R2 = 25'(COL_R * COL_R);

    typedef enum logic [3:0] {
        IDLE, SNAP, P1_DIFF, P1_SQ, P1_CMP, P2_DIFF, P2_SQ, P2_CMP, NET_CMP, COMMIT
    } state_t;

    state_t        state;
    logic [CW-1:0] smp_cnt;
    logic [11:0]   s_bx, s_by, s_p1x, s_p1y, s_p2x, s_p2y;
    logic [11:0]   adx, ady;
    logic [23:0]   sqx, sqy;
    logic          hit_pl1, hit_pl2, hit_net;

    logic [11:0]   px_sel, py_sel;
    logic [12:0]   dx, dy, bx64, by64;
    logic [11:0]   adx_n, ady_n;
    logic [24:0]   dsum;
    logic          net_n;
    logic          commit;
    logic [2:0]    hit_vec, col_vec;

    // Shared datapath: player operand chosen by the current DIFF state; negative
    // differences (ball left of / above the player centre) are folded to magnitudes.
    always_comb begin
        px_sel = (state == P2_DIFF) ? s_p2x : s_p1x;
        py_sel = (state == P2_DIFF) ? s_p2y : s_p1y;
        dx     = ({1'b0, s_bx} + 13'(BALL_R)) - ({1'b0, px_sel} + 13'(PL_CX));
        dy     = ({1'b0, s_by} + 13'(BALL_R)) - ({1'b0, py_sel} + 13'(PL_CY));
        adx_n  = dx[12] ? (~dx[11:0] + 12'd1) : dx[11:0];
        ady_n  = dy[12] ? (~dy[11:0] + 12'd1) : dy[11:0];
        dsum   = {1'b0, sqx} + {1'b0, sqy};
        bx64   = {1'b0, s_bx} + 13'd64;
        by64   = {1'b0, s_by} + 13'd64;
        net_n  = (bx64 >= 13'(NET_XL)) && ({1'b0, s_bx} <= 13'(NET_XR)) &&
                 (by64 >= 13'(NET_TOP));
    end

    assign commit  = (state == COMMIT);
    assign hit_vec = {hit_net, hit_pl2, hit_pl1};

    // Free-running sample divider; its terminal count launches an evaluation
    always_ff @(posedge clk) begin
        if (rst)                                smp_cnt <= '0;
        else if (smp_cnt == CW'(SAMPLE_DIV - 1)) smp_cnt <= '0;
        else                                    smp_cnt <= smp_cnt + 1'b1;
    end

    // Evaluation sequencer: one step per clock, working only on the snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_bx      <= '0; s_by  <= '0;
            s_p1x     <= '0; s_p1y <= '0;
            s_p2x     <= '0; s_p2y <= '0;
            adx       <= '0; ady   <= '0;
            sqx       <= '0; sqy   <= '0;
            hit_pl1   <= 1'b0;
            hit_pl2   <= 1'b0;
            hit_net   <= 1'b0;
            hit_valid <= 1'b0;
        end else begin
            hit_valid <= 1'b0;
            case (state)
                IDLE:    if (smp_cnt == CW'(SAMPLE_DIV - 1)) state <= SNAP;
                SNAP: begin
                    s_bx  <= ball_posx; s_by  <= ball_posy;
                    s_p1x <= pl1_posx;  s_p1y <= pl1_posy;
                    s_p2x <= pl2_posx;  s_p2y <= pl2_posy;
                    state <= P1_DIFF;
                end
                P1_DIFF: begin adx <= adx_n; ady <= ady_n; state <= P1_SQ; end
                P1_SQ: begin
                    sqx   <= {12'd0, adx} * {12'd0, adx};
                    sqy   <= {12'd0, ady} * {12'd0, ady};
                    state <= P1_CMP;
                end
                P1_CMP:  begin hit_pl1 <= (dsum <= COL_R2); state <= P2_DIFF; end
                P2_DIFF: begin adx <= adx_n; ady <= ady_n; state <= P2_SQ; end
                P2_SQ: begin
                    sqx   <= {12'd0, adx} * {12'd0, adx};
                    sqy   <= {12'd0, ady} * {12'd0, ady};
                    state <= P2_CMP;
                end
                P2_CMP:  begin hit_pl2 <= (dsum <= COL_R2); state <= NET_CMP; end
                NET_CMP: begin hit_net <= net_n; state <= COMMIT; end
                COMMIT:  begin hit_valid <= 1'b1; state <= IDLE; end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-flag hit stretchers: reload on a committed hit, otherwise count down to 0
    for (genvar i = 0; i < 3; i++) begin : g_hold
        logic [HW-1:0] hold_q, hold_d;
        logic          col_q;

        always_comb begin
            hold_d = hold_q;
            if (commit && hit_vec[i]) hold_d = HW'(HOLD_CYCLES);
            else if (hold_q != '0)    hold_d = hold_q - 1'b1;
        end

        // Flag register tracks the next hold count so it drops the same cycle the count expires
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
                col_q  <= 1'b0;
            end else begin
                hold_q <= hold_d;
                col_q  <= (hold_d != '0);
            end
        end

        assign col_vec[i] = col_q;
    end

    assign pl1_col = col_vec[0];
    assign pl2_col = col_vec[1];
    assign net_col = col_vec[2];
endmodule
